// File: rtl/multich_maxpool2x2.sv
// 2x2 stride-2 max-pooling stage for CH packed channels.
// Optional build macro: MAXPOOL_RELU_EN clamps negative results to zero (SIGNED=1 only).
module multich_maxpool2x2 #(
  parameter int DW     = 19,
  parameter int CH     = 3,
  parameter int COLS   = 24,
  parameter int ROWS   = 24,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clear,
  input  logic               i_in_valid,
  input  logic [CH*DW-1:0]   i_in_fmap,
  output logic               o_ot_valid,
  output logic [CH*DW-1:0]   o_ot_fmap,
  output logic               o_ot_last
);

  localparam int CW = (COLS > 2) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam int BD = (COLS / 2 > 0) ? COLS / 2 : 1;
  localparam int BW = (CW > 1) ? CW - 1 : 1;
  localparam int PW = CH * DW;

  if ((COLS % 2) != 0 || (ROWS % 2) != 0 || COLS < 2 || ROWS < 2 || CH < 1) begin : g_bad_params
    $fatal(1, "multich_maxpool2x2: COLS and ROWS must be even and >= 2, CH must be >= 1");
  end

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [PW-1:0] r_pair;
  logic [PW-1:0] r_rowbuf [BD];

  logic          w_accept;
  logic          w_colOdd;
  logic          w_rowOdd;
  logic          w_colEnd;
  logic          w_rowEnd;
  logic [BW-1:0] w_idx;
  logic [PW-1:0] w_rdPair;
  logic [PW-1:0] w_hmax;
  logic [PW-1:0] w_result;

  function automatic logic [DW-1:0] fMax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic aWins;
    if (SIGNED != 0) aWins = ($signed(a) > $signed(b));
    else             aWins = (a > b);
    return aWins ? a : b;
  endfunction

  assign w_accept = i_in_valid & ~i_clear;
  assign w_colOdd = r_col[0];
  assign w_rowOdd = r_row[0];
  assign w_colEnd = (r_col == CW'(COLS - 1));
  assign w_rowEnd = (r_row == RW'(ROWS - 1));

  // Rowbuf slot is the pooled column, i.e. the column counter without its LSB.
  if (CW > 1) begin : g_idx_wide
    assign w_idx = r_col[CW-1:1];
  end else begin : g_idx_narrow
    assign w_idx = '0;
  end

  assign w_rdPair = r_rowbuf[w_idx];

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [DW-1:0] w_h;
    logic [DW-1:0] w_v;
    assign w_h = fMax(r_pair[k*DW +: DW], i_in_fmap[k*DW +: DW]);
    assign w_v = fMax(w_rdPair[k*DW +: DW], w_h);
    assign w_hmax[k*DW +: DW] = w_h;
`ifdef MAXPOOL_RELU_EN
    assign w_result[k*DW +: DW] = ((SIGNED != 0) && w_v[DW-1]) ? '0 : w_v;
`else
    assign w_result[k*DW +: DW] = w_v;
`endif
  end

  // Raster counters, pair register and registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_pair     <= '0;
      o_ot_valid <= 1'b0;
      o_ot_fmap  <= '0;
      o_ot_last  <= 1'b0;
    end else if (i_clear) begin
      r_col      <= '0;
      r_row      <= '0;
      r_pair     <= '0;
      o_ot_valid <= 1'b0;
      o_ot_last  <= 1'b0;
    end else begin
      o_ot_valid <= 1'b0;
      o_ot_last  <= 1'b0;
      if (i_in_valid) begin
        if (w_colEnd) begin
          r_col <= '0;
          r_row <= w_rowEnd ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (!w_colOdd) r_pair <= i_in_fmap;
        if (w_colOdd && w_rowOdd) begin
          o_ot_valid <= 1'b1;
          o_ot_fmap  <= w_result;
          o_ot_last  <= w_rowEnd && w_colEnd;
        end
      end
    end
  end

  // Even rows park their horizontal pair-maxima for the odd row below.
  always_ff @(posedge clk) begin
    if (w_accept && w_colOdd && !w_rowOdd) r_rowbuf[w_idx] <= w_hmax;
  end

endmodule

// File: tb/tb_multich_maxpool2x2.sv
// Self-checking bench for multich_maxpool2x2 on a 4x4, 2-channel, 8-bit signed build.
module tb_multich_maxpool2x2;

  localparam int DW = 8;
  localparam int CH = 2;
  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int SIGNED = 1;
  localparam int PW = CH * DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_clear = 1'b0;
  logic          i_in_valid = 1'b0;
  logic [PW-1:0] i_in_fmap = '0;
  logic          o_ot_valid;
  logic [PW-1:0] o_ot_fmap;
  logic          o_ot_last;

  multich_maxpool2x2 #(
    .DW(DW), .CH(CH), .COLS(COLS), .ROWS(ROWS), .SIGNED(SIGNED)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_clear(i_clear),
    .i_in_valid(i_in_valid),
    .i_in_fmap(i_in_fmap),
    .o_ot_valid(o_ot_valid),
    .o_ot_fmap(o_ot_fmap),
    .o_ot_last(o_ot_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pix;
    logic          expValid;
    logic [PW-1:0] expFmap;
    logic          expLast;
  } vec_t;

  vec_t          vecs[32];
  int            checks = 0;
  int            errors = 0;
  int            mRow = 0;
  int            mCol = 0;
  logic [PW-1:0] lastFmap = '0;
  logic [PW-1:0] mdlFrame [ROWS][COLS];

  function automatic logic [PW-1:0] pack2(input int c1, input int c0);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = DW'(c1);
    b = DW'(c0);
    return {a, b};
  endfunction

  // Reference: max over the four stored pixels of the window ending at (r,c).
  function automatic logic [PW-1:0] poolWindow(input int r, input int c);
    logic [PW-1:0] res;
    logic [PW-1:0] p;
    int best;
    int v;
    res = '0;
    for (int ch = 0; ch < CH; ch++) begin
      best = -100000;
      for (int dr = 0; dr < 2; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          p = mdlFrame[r-1+dr][c-1+dc];
          v = $signed(p[ch*DW +: DW]);
          if (v > best) best = v;
        end
      end
`ifdef MAXPOOL_RELU_EN
      if (best < 0) best = 0;
`endif
      res[ch*DW +: DW] = DW'(best);
    end
    return res;
  endfunction

  task automatic modelAccept(input logic [PW-1:0] pix, output logic expV,
                             output logic [PW-1:0] expF, output logic expL);
    mdlFrame[mRow][mCol] = pix;
    if ((mRow % 2 == 1) && (mCol % 2 == 1)) begin
      expV = 1'b1;
      expF = poolWindow(mRow, mCol);
      lastFmap = expF;
      expL = (mRow == ROWS - 1) && (mCol == COLS - 1);
    end else begin
      expV = 1'b0;
      expF = lastFmap;
      expL = 1'b0;
    end
    mCol++;
    if (mCol == COLS) begin
      mCol = 0;
      mRow = (mRow + 1) % ROWS;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic c, input logic [PW-1:0] p);
    i_in_valid = v;
    i_clear    = c;
    i_in_fmap  = p;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_clear    = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic expV,
                             input logic [PW-1:0] expF, input logic expL);
    checks++;
    if (o_ot_valid !== expV) begin
      errors++;
      $display("[TB] FAIL %s valid got %0b want %0b", name, o_ot_valid, expV);
    end
    checks++;
    if (o_ot_fmap !== expF) begin
      errors++;
      $display("[TB] FAIL %s fmap got %h want %h", name, o_ot_fmap, expF);
    end
    checks++;
    if (o_ot_last !== expL) begin
      errors++;
      $display("[TB] FAIL %s last got %0b want %0b", name, o_ot_last, expL);
    end
  endtask

  task automatic sendPixel(input string name, input logic [PW-1:0] pix);
    logic          v;
    logic [PW-1:0] f;
    logic          l;
    modelAccept(pix, v, f, l);
    applyStimulus(1'b1, 1'b0, pix);
    checkOutput(name, v, f, l);
  endtask

  task automatic bubble(input string name);
    applyStimulus(1'b0, 1'b0, PW'($urandom));
    checkOutput(name, 1'b0, lastFmap, 1'b0);
  endtask

  task automatic clearCycle(input string name, input logic v, input logic [PW-1:0] pix);
    applyStimulus(v, 1'b1, pix);
    mRow = 0;
    mCol = 0;
    checkOutput(name, 1'b0, lastFmap, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [PW-1:0] held;
    logic          dv;
    logic [PW-1:0] df;
    logic          dl;
    int            chIn0 [16];
    int            chIn1 [16];

    // Table part 1: pixel i carries value i on both channels.
    held = '0;
    for (int i = 0; i < 16; i++) begin
      vecs[i].pix      = pack2(i, i);
      vecs[i].expValid = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      if (vecs[i].expValid) held = pack2(i, i);
      vecs[i].expFmap  = held;
      vecs[i].expLast  = (i == 15);
    end
    // Table part 2: signed window at the top-left, zeros elsewhere.
    for (int i = 0; i < 16; i++) begin
      chIn0[i] = 0;
      chIn1[i] = 0;
    end
    chIn0[0] = -3; chIn0[1] = -1; chIn0[4] = -8; chIn0[5] = -2;
    chIn1[0] = 4;  chIn1[1] = -9; chIn1[4] = 0;  chIn1[5] = 2;
    for (int i = 0; i < 16; i++) begin
      vecs[16+i].pix      = pack2(chIn1[i], chIn0[i]);
      vecs[16+i].expValid = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      if (i == 5) begin
`ifdef MAXPOOL_RELU_EN
        held = pack2(4, 0);
`else
        held = pack2(4, -1);
`endif
      end else if (vecs[16+i].expValid) begin
        held = pack2(0, 0);
      end
      vecs[16+i].expFmap = held;
      vecs[16+i].expLast = (i == 15);
    end

    #12;
    checkOutput("reset_state", 1'b0, '0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_reset", 1'b0, '0, 1'b0);

    $display("[TB] table vectors");
    for (int i = 0; i < 32; i++) begin
      modelAccept(vecs[i].pix, dv, df, dl);
      applyStimulus(1'b1, 1'b0, vecs[i].pix);
      checkOutput($sformatf("table%0d", i), vecs[i].expValid, vecs[i].expFmap, vecs[i].expLast);
    end

    $display("[TB] ramp with random bubbles");
    for (int i = 0; i < 16; i++) begin
      int nb;
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) bubble($sformatf("bubble%0d_%0d", i, b));
      sendPixel($sformatf("ramp%0d", i), pack2(15 - i, i));
    end

    $display("[TB] two back-to-back random frames");
    for (int i = 0; i < 32; i++) begin
      sendPixel($sformatf("b2b%0d", i), pack2($urandom_range(0, 255), $urandom_range(0, 255)));
    end

    $display("[TB] mid-frame clear");
    for (int i = 0; i < 5; i++) begin
      sendPixel($sformatf("abort%0d", i), pack2($urandom_range(0, 255), $urandom_range(0, 255)));
    end
    clearCycle("clear_with_valid", 1'b1, pack2(127, 127));
    bubble("post_clear");
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) bubble($sformatf("clean_bub%0d", i));
      sendPixel($sformatf("clean%0d", i), pack2($urandom_range(0, 255), $urandom_range(0, 255)));
    end

    $display("[TB] mid-frame async reset");
    for (int i = 0; i < 6; i++) begin
      sendPixel($sformatf("prerst%0d", i), pack2($urandom_range(1, 100), $urandom_range(1, 100)));
    end
    #2;
    reset_n = 1'b0;
    #1;
    mRow = 0;
    mCol = 0;
    lastFmap = '0;
    checkOutput("async_reset", 1'b0, '0, 1'b0);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset", 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      sendPixel($sformatf("postrst%0d", i), pack2($urandom_range(0, 255), $urandom_range(0, 255)));
    end
    bubble("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
